// File: rtl/rom_program_loader.sv
// Boot loader: parses a framed byte stream (SYNC, LEN_HI, LEN_LO, payload[, CHK]) into the ROM
// write port and holds the core in reset until a complete image is stored. Optional macro: LOADER_CHECKSUM_EN.
module rom_program_loader #(
    parameter int          ADDR_WIDTH = 12,
    parameter int          DATA_WIDTH = 8,
    parameter logic [7:0]  SYNC_BYTE  = 8'hA5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  restart,
    output logic                  rom_we,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    output logic [DATA_WIDTH-1:0] rom_wdata,
    output logic                  core_hold,
    output logic                  load_done,
    output logic                  load_error
);

    typedef enum logic [2:0] {
        S_SYNC   = 3'd0,
        S_LEN_HI = 3'd1,
        S_LEN_LO = 3'd2,
        S_DATA   = 3'd3,
`ifdef LOADER_CHECKSUM_EN
        S_CHK    = 3'd4,
`endif
        S_DONE   = 3'd5,
        S_ERROR  = 3'd6
    } state_t;

    state_t                  state_q, state_d;
    logic [11:0]             len_q, len_d;
    logic [ADDR_WIDTH-1:0]   count_q, count_d;
    logic                    in_ready_q, in_ready_d;
    logic                    rom_we_q, rom_we_d;
    logic [ADDR_WIDTH-1:0]   rom_addr_q, rom_addr_d;
    logic [DATA_WIDTH-1:0]   rom_wdata_q, rom_wdata_d;
    logic                    core_hold_q, core_hold_d;
    logic                    load_done_q, load_done_d;
    logic                    load_error_q, load_error_d;
    logic                    xfer_s;
    logic [11:0]             len_full_s;

`ifdef LOADER_CHECKSUM_EN
    logic [7:0]              sum_q, sum_d;

    // A frame is good when the payload sum plus the check byte wraps to zero.
    function automatic logic checksum_ok(input logic [7:0] sum, input logic [7:0] chk);
        logic [7:0] total;
        total = sum + chk;
        return (total == 8'h00);
    endfunction
`endif

    assign xfer_s     = in_valid && in_ready_q;
    assign len_full_s = {len_q[11:8], in_data};

    // Next-state, counter and write-port computation.
    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        count_d     = count_q;
        rom_we_d    = 1'b0;
        rom_addr_d  = rom_addr_q;
        rom_wdata_d = rom_wdata_q;
`ifdef LOADER_CHECKSUM_EN
        sum_d       = sum_q;
`endif
        case (state_q)
            S_SYNC: begin
                if (xfer_s && (in_data == SYNC_BYTE)) begin
                    state_d = S_LEN_HI;
                    len_d   = 12'd0;
                    count_d = '0;
`ifdef LOADER_CHECKSUM_EN
                    sum_d   = 8'h00;
`endif
                end else begin
                    state_d = S_SYNC;
                end
            end
            S_LEN_HI: begin
                if (xfer_s) begin
                    if (in_data[7:4] != 4'h0) begin
                        state_d = S_ERROR;
                    end else begin
                        len_d   = {in_data[3:0], 8'h00};
                        state_d = S_LEN_LO;
                    end
                end else begin
                    state_d = S_LEN_HI;
                end
            end
            S_LEN_LO: begin
                if (xfer_s) begin
                    len_d = len_full_s;
                    if (len_full_s == 12'd0) begin
`ifdef LOADER_CHECKSUM_EN
                        state_d = S_CHK;
`else
                        state_d = S_DONE;
`endif
                    end else begin
                        state_d = S_DATA;
                    end
                end else begin
                    state_d = S_LEN_LO;
                end
            end
            S_DATA: begin
                if (xfer_s) begin
                    rom_we_d    = 1'b1;
                    rom_addr_d  = count_q;
                    rom_wdata_d = in_data;
                    count_d     = count_q + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
`ifdef LOADER_CHECKSUM_EN
                    sum_d       = sum_q + in_data;
`endif
                    // len_q is nonzero here, so len_q-1 is the last address.
                    if (count_q == ADDR_WIDTH'(len_q - 12'd1)) begin
`ifdef LOADER_CHECKSUM_EN
                        state_d = S_CHK;
`else
                        state_d = S_DONE;
`endif
                    end else begin
                        state_d = S_DATA;
                    end
                end else begin
                    state_d = S_DATA;
                end
            end
`ifdef LOADER_CHECKSUM_EN
            S_CHK: begin
                if (xfer_s) begin
                    state_d = checksum_ok(sum_q, in_data) ? S_DONE : S_ERROR;
                end else begin
                    state_d = S_CHK;
                end
            end
`endif
            S_DONE, S_ERROR: begin
                if (restart) begin
                    state_d = S_SYNC;
                    len_d   = 12'd0;
                    count_d = '0;
`ifdef LOADER_CHECKSUM_EN
                    sum_d   = 8'h00;
`endif
                end else begin
                    state_d = state_q;
                end
            end
            default: begin
                state_d = S_SYNC;
            end
        endcase

        in_ready_d   = (state_d != S_DONE) && (state_d != S_ERROR);
        load_done_d  = (state_d == S_DONE);
        load_error_d = (state_d == S_ERROR);
        // The core is released only once DONE has been held for a full cycle.
        core_hold_d  = !((state_q == S_DONE) && (state_d == S_DONE));
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_SYNC;
            len_q        <= 12'd0;
            count_q      <= '0;
            in_ready_q   <= 1'b0;
            rom_we_q     <= 1'b0;
            rom_addr_q   <= '0;
            rom_wdata_q  <= '0;
            core_hold_q  <= 1'b1;
            load_done_q  <= 1'b0;
            load_error_q <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            sum_q        <= 8'h00;
`endif
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            count_q      <= count_d;
            in_ready_q   <= in_ready_d;
            rom_we_q     <= rom_we_d;
            rom_addr_q   <= rom_addr_d;
            rom_wdata_q  <= rom_wdata_d;
            core_hold_q  <= core_hold_d;
            load_done_q  <= load_done_d;
            load_error_q <= load_error_d;
`ifdef LOADER_CHECKSUM_EN
            sum_q        <= sum_d;
`endif
        end
    end

    assign in_ready   = in_ready_q;
    assign rom_we     = rom_we_q;
    assign rom_addr   = rom_addr_q;
    assign rom_wdata  = rom_wdata_q;
    assign core_hold  = core_hold_q;
    assign load_done  = load_done_q;
    assign load_error = load_error_q;

endmodule

// File: tb/tb_rom_program_loader.sv
// Directed bench for rom_program_loader: frame-level model predicts ROM writes and the final status.
module tb_rom_program_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_valid = 1'b0;
    logic        restart = 1'b0;
    logic        in_ready, rom_we, core_hold, load_done, load_error;
    logic [11:0] rom_addr;
    logic [7:0]  rom_wdata;

    rom_program_loader dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .restart(restart), .rom_we(rom_we), .rom_addr(rom_addr),
        .rom_wdata(rom_wdata), .core_hold(core_hold), .load_done(load_done),
        .load_error(load_error)
    );

    always #5 clk = ~clk;

    typedef struct {
        int addr;
        int data;
    } wr_t;

    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    wr_t  exp_q[$];
    int   pulse_cyc[$];
    logic [7:0] frame[$];
    wr_t  m_writes[$];
    int   m_outcome;   // 0 incomplete, 1 done, 2 error
    int   m_consumed;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Frame-level model: locate sync, decode length, list payload writes and outcome.
    task automatic model_frame();
        int i;
        int len;
        int p;
        logic [7:0] hi;
        logic [7:0] sum;
        m_writes.delete();
        m_outcome  = 0;
        m_consumed = frame.size();
        i = 0;
        while (i < frame.size() && frame[i] != 8'hA5) i++;
        if (i + 1 >= frame.size()) return;
        hi = frame[i+1];
        if (hi[7:4] != 4'h0) begin
            m_outcome  = 2;
            m_consumed = i + 2;
            return;
        end
        if (i + 2 >= frame.size()) return;
        len = hi[3:0] * 256 + frame[i+2];
        p   = i + 3;
        sum = 8'h00;
        for (int k = 0; k < len; k++) begin
            wr_t w;
            if (p + k >= frame.size()) return;
            w.addr = k;
            w.data = frame[p+k];
            m_writes.push_back(w);
            sum = sum + frame[p+k];
        end
`ifdef LOADER_CHECKSUM_EN
        if (p + len >= frame.size()) return;
        m_consumed = p + len + 1;
        sum = sum + frame[p+len];
        m_outcome = (sum == 8'h00) ? 1 : 2;
`else
        m_consumed = p + len;
        m_outcome  = 1;
`endif
    endtask

    // Appends the byte that makes the payload sum wrap to zero (checksum builds only).
    task automatic append_chk(input int sync_idx);
        logic [7:0] s;
        s = 8'h00;
        for (int k = sync_idx + 3; k < frame.size(); k++) s = s + frame[k];
        frame.push_back(8'h00 - s);
    endtask

    // Every cycle: each write pulse must match the next predicted write.
    always @(negedge clk) begin
        wr_t w;
        cyc++;
        if (rom_we === 1'b1) begin
            pulse_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
                chk("unexpected_rom_we", 32'd1, 32'd0);
            end else begin
                w = exp_q.pop_front();
                chk("rom_addr", 32'(rom_addr), 32'(w.addr));
                chk("rom_wdata", 32'(rom_wdata), 32'(w.data));
            end
        end else if (rom_we !== 1'b0) begin
            chk("rom_we_known", 32'(rom_we), 32'd0);
        end
    end

    task automatic run_frame();
        int n;
        model_frame();
        foreach (m_writes[k]) exp_q.push_back(m_writes[k]);
        pulse_cyc.delete();
        for (int k = 0; k < m_consumed; k++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = frame[k];
            n = 0;
            while (in_ready !== 1'b1 && n < 20) begin
                @(negedge clk);
                n++;
            end
            if (n >= 20) begin
                chk("in_ready_timeout", 32'd0, 32'd1);
                break;
            end
            @(posedge clk);
        end
        @(negedge clk);
        in_valid = 1'b0;
        if (m_outcome == 1) begin
            chk("done_load_done", 32'(load_done), 32'd1);
            chk("done_core_hold_first", 32'(core_hold), 32'd1);
            chk("done_in_ready", 32'(in_ready), 32'd0);
            chk("done_load_error", 32'(load_error), 32'd0);
            @(negedge clk);
            chk("done_core_hold_released", 32'(core_hold), 32'd0);
            chk("done_load_done_held", 32'(load_done), 32'd1);
        end else if (m_outcome == 2) begin
            chk("err_load_error", 32'(load_error), 32'd1);
            chk("err_in_ready", 32'(in_ready), 32'd0);
            chk("err_core_hold", 32'(core_hold), 32'd1);
            chk("err_load_done", 32'(load_done), 32'd0);
        end
        if (m_outcome != 0) begin
            repeat (2) @(negedge clk);
            chk("writes_pending", 32'(exp_q.size()), 32'd0);
        end
    endtask

    task automatic do_restart();
        @(negedge clk);
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        chk("restart_load_done", 32'(load_done), 32'd0);
        chk("restart_load_error", 32'(load_error), 32'd0);
        chk("restart_core_hold", 32'(core_hold), 32'd1);
        chk("restart_in_ready", 32'(in_ready), 32'd1);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd0);
        chk({tag, "_rom_we"}, 32'(rom_we), 32'd0);
        chk({tag, "_rom_addr"}, 32'(rom_addr), 32'd0);
        chk({tag, "_rom_wdata"}, 32'(rom_wdata), 32'd0);
        chk({tag, "_core_hold"}, 32'(core_hold), 32'd1);
        chk({tag, "_load_done"}, 32'(load_done), 32'd0);
        chk({tag, "_load_error"}, 32'(load_error), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        chk_reset_outputs("reset");
        reset = 1'b1;
        #1;
        chk("in_ready_after_release", 32'(in_ready), 32'd0);
        @(negedge clk);
        chk("in_ready_first_clock", 32'(in_ready), 32'd1);

        // Back-to-back three-byte image.
        frame = '{8'hA5, 8'h00, 8'h03, 8'h11, 8'h22, 8'h33};
`ifdef LOADER_CHECKSUM_EN
        append_chk(0);
`endif
        model_frame();
        chk("model_a_nwrites", 32'(m_writes.size()), 32'd3);
        chk("model_a_last_addr", 32'(m_writes[2].addr), 32'd2);
        chk("model_a_last_data", 32'(m_writes[2].data), 32'h33);
        run_frame();
        chk("a_pulse_count", 32'(pulse_cyc.size()), 32'd3);
        if (pulse_cyc.size() == 3) begin
            chk("a_b2b_1", 32'(pulse_cyc[1] - pulse_cyc[0]), 32'd1);
            chk("a_b2b_2", 32'(pulse_cyc[2] - pulse_cyc[1]), 32'd1);
        end

        // Leading junk discarded before sync.
        do_restart();
        frame = '{8'h00, 8'hFF, 8'hA5, 8'h00, 8'h01, 8'h7E};
`ifdef LOADER_CHECKSUM_EN
        append_chk(2);
`endif
        model_frame();
        chk("model_b_nwrites", 32'(m_writes.size()), 32'd1);
        run_frame();

        // Bad LEN_HI: error, bytes refused while in ERROR, then restart.
        do_restart();
        frame = '{8'hA5, 8'h10};
        model_frame();
        chk("model_c_outcome", 32'(m_outcome), 32'd2);
        run_frame();
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 8'hA5;
        repeat (3) @(negedge clk);
        chk("c_hold_in_ready", 32'(in_ready), 32'd0);
        chk("c_hold_error", 32'(load_error), 32'd1);
        in_valid = 1'b0;
        do_restart();

        // Zero-length image.
        frame = '{8'hA5, 8'h00, 8'h00};
`ifdef LOADER_CHECKSUM_EN
        append_chk(0);
`endif
        run_frame();
        chk("zero_len_pulses", 32'(pulse_cyc.size()), 32'd0);

`ifdef LOADER_CHECKSUM_EN
        do_restart();
        frame = '{8'hA5, 8'h00, 8'h02, 8'h10, 8'h20, 8'hD0};
        model_frame();
        chk("model_chk_good", 32'(m_outcome), 32'd1);
        run_frame();
        do_restart();
        frame = '{8'hA5, 8'h00, 8'h02, 8'h10, 8'h20, 8'hD1};
        model_frame();
        chk("model_chk_bad", 32'(m_outcome), 32'd2);
        run_frame();
        chk("chk_bad_pulses", 32'(pulse_cyc.size()), 32'd2);
`endif

        // Asynchronous reset after the second payload byte of a LEN=5 frame.
        do_restart();
        frame = '{8'hA5, 8'h00, 8'h05, 8'h01, 8'h02};
        run_frame();
        #1;
        reset = 1'b0;
        #1;
        chk_reset_outputs("midframe");
        chk("midframe_writes_seen", 32'(exp_q.size()), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("midframe_in_ready_back", 32'(in_ready), 32'd1);
        frame = '{8'hA5, 8'h00, 8'h02, 8'hC3, 8'h3C};
`ifdef LOADER_CHECKSUM_EN
        append_chk(0);
`endif
        run_frame();
        chk("reload_pulses", 32'(pulse_cyc.size()), 32'd2);

        chk("final_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
